servo_pwm_multi: RTL



---
 rtl/servo_pkg.sv | 23 ++
 rtl/servo_pwm_multi_if.sv | 17 +
 rtl/servo_chan.sv | 88 ++++++++
 rtl/servo_pwm_multi.sv | 71 +++++++
 4 files changed

// File: rtl/servo_pkg.sv
// Shared servo timing constants, the channel slew decision type and the
// parameter sanity check used at elaboration.
package servo_pkg;

  // 50 Hz frame at a 50 MHz clock and the standard hobby-servo pulse widths.
  localparam int PERIOD_50HZ  = 1_000_000;
  localparam int TICKS_0DEG   = 25_000;
  localparam int TICKS_90DEG  = 75_000;
  localparam int TICKS_180DEG = 125_000;

  // How a channel's width register moves at a frame boundary.
  typedef enum logic [1:0] {
    SLEW_SNAP = 2'd0,  // jump straight to the target
    SLEW_UP   = 2'd1,  // target is more than one step above
    SLEW_DOWN = 2'd2   // target is more than one step below
  } slew_e;

  // Widths must sit in a window that never covers a whole frame.
  function automatic bit timing_ok(int min_t, int init_t, int max_t, int period);
    return (min_t <= init_t) && (init_t <= max_t) && (max_t < period);
  endfunction

endpackage

// File: rtl/servo_pwm_multi_if.sv
// Command/output bundle of the multi-channel servo driver. There is no
// valid/ready handshake: pos and en are level inputs, and pos is only taken
// in the last cycle of each frame (the boundary), so the producer just holds
// the wanted value across that cycle.
interface servo_pwm_multi_if #(
  parameter int N_CH  = 5,
  parameter int POS_W = 15
);
  logic [N_CH*POS_W-1:0] pos;
  logic [N_CH-1:0]       en;
  logic [N_CH-1:0]       pwm;
  logic                  frame_tick;
  logic [N_CH-1:0]       busy;

  modport master (output pos, en, input pwm, frame_tick, busy);
  modport slave  (input pos, en, output pwm, frame_tick, busy);
endinterface

// File: rtl/servo_chan.sv
// One servo channel: position-to-width mapping with clamp, optional per-frame
// slew limit, busy flag and the registered PWM comparator.
module servo_chan
  import servo_pkg::*;
#(
  parameter int CNT_W      = 20,
  parameter int POS_W      = 15,
  parameter int MIN_TICKS  = TICKS_0DEG,
  parameter int MAX_TICKS  = TICKS_180DEG,
  parameter int SCALE      = 3,
  parameter int INIT_TICKS = TICKS_90DEG,
  parameter int STEP       = 0
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [CNT_W-1:0] cnt,
  input  logic             bound,
  input  logic [POS_W-1:0] pos,
  input  logic             en,
  output logic             pwm,
  output logic             busy
);

  // Target arithmetic is one bit wider than the counter so the unclamped
  // sum never wraps; slew compares get one more bit for w + STEP.
  localparam int TW = CNT_W + 1;
  localparam int SW = CNT_W + 2;
  localparam logic [TW-1:0] MIN_T  = TW'(MIN_TICKS);
  localparam logic [TW-1:0] MAX_T  = TW'(MAX_TICKS);
  localparam logic [TW-1:0] INIT_T = TW'(INIT_TICKS);
  localparam logic [TW-1:0] SCL_T  = TW'(SCALE);
  localparam logic [TW-1:0] STEP_T = TW'(STEP);
  localparam logic [SW-1:0] STEP_S = SW'(STEP);

  logic [TW-1:0] tgt_raw;
  logic [TW-1:0] tgt;
  logic [TW-1:0] w;
  logic [TW-1:0] w_nxt;
  logic [SW-1:0] w_s;
  logic [SW-1:0] t_s;
  slew_e         slew;

  assign tgt_raw = MIN_T + TW'(pos) * SCL_T;
  assign tgt     = (tgt_raw > MAX_T) ? MAX_T : tgt_raw;
  assign w_s     = SW'(w);
  assign t_s     = SW'(tgt);

  // Choose the next width: snap to target unless a step limit applies.
  always_comb begin
    slew  = SLEW_SNAP;
    w_nxt = tgt;
    if (STEP != 0) begin
      if (t_s > w_s + STEP_S) begin
        slew = SLEW_UP;
      end else if (t_s + STEP_S < w_s) begin
        slew = SLEW_DOWN;
      end
    end
    case (slew)
      SLEW_UP:   w_nxt = w + STEP_T;
      SLEW_DOWN: w_nxt = w - STEP_T;
      default:   w_nxt = tgt;
    endcase
  end

  // Width and busy only move at the frame boundary; busy reflects whether
  // the value just written still differs from the target sampled with it.
  always_ff @(posedge CLK) begin
    if (RST) begin
      w    <= INIT_T;
      busy <= 1'b0;
    end else if (bound) begin
      w    <= w_nxt;
      busy <= (w_nxt != tgt);
    end
  end

  // Pulse is high while the frame counter is below the width; enable gates
  // it immediately rather than at the next frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      pwm <= 1'b0;
    end else begin
      pwm <= en & ({1'b0, cnt} < w);
    end
  end

endmodule

// File: rtl/servo_pwm_multi.sv
// N-channel servo PWM generator: one shared frame counter and boundary
// strobe, one servo_chan per channel.
module servo_pwm_multi
  import servo_pkg::*;
#(
  parameter int N_CH       = 5,
  parameter int POS_W      = 15,
  parameter int PERIOD     = PERIOD_50HZ,
  parameter int MIN_TICKS  = TICKS_0DEG,
  parameter int MAX_TICKS  = TICKS_180DEG,
  parameter int SCALE      = 3,
  parameter int INIT_TICKS = TICKS_90DEG,
  parameter int STEP       = 0
) (
  input logic CLK,
  input logic RST,
  servo_pwm_multi_if.slave bus
);

  localparam int CNT_W = $clog2(PERIOD);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

  if (!timing_ok(MIN_TICKS, INIT_TICKS, MAX_TICKS, PERIOD)) begin : g_bad_timing
    $error("servo_pwm_multi: need MIN_TICKS <= INIT_TICKS <= MAX_TICKS < PERIOD");
  end

  logic [CNT_W-1:0] cnt;
  logic             bound;
  logic             frame_tick_q;
  logic [N_CH-1:0]  pwm_v;
  logic [N_CH-1:0]  busy_v;

  assign bound = (cnt == LAST);

  // Frame counter 0..PERIOD-1 and the strobe marking the first cycle of a frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt          <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      cnt          <= bound ? '0 : cnt + 1'b1;
      frame_tick_q <= bound;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    servo_chan #(
      .CNT_W      (CNT_W),
      .POS_W      (POS_W),
      .MIN_TICKS  (MIN_TICKS),
      .MAX_TICKS  (MAX_TICKS),
      .SCALE      (SCALE),
      .INIT_TICKS (INIT_TICKS),
      .STEP       (STEP)
    ) u_chan (
      .CLK   (CLK),
      .RST   (RST),
      .cnt   (cnt),
      .bound (bound),
      .pos   (bus.pos[i*POS_W +: POS_W]),
      .en    (bus.en[i]),
      .pwm   (pwm_v[i]),
      .busy  (busy_v[i])
    );
  end

  assign bus.pwm        = pwm_v;
  assign bus.busy       = busy_v;
  assign bus.frame_tick = frame_tick_q;

endmodule
